// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes WIDTH bits as WIDTH/CHUNK slices, LSB first,
// one slice per clock, with the carry rippled through a register between slices.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   chunk_sum;

    always_comb begin
        base      = 32'(idx_q) * 32'(CHUNK);
        a_slice   = a_q[base +: CHUNK];
        b_slice   = b_q[base +: CHUNK];
        chunk_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
                    a_d     = A;
                    b_d     = SUB ? ~B : B;
                    carry_d = SUB ? 1'b1 : Cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d            = chunk_sum[CHUNK];
                idx_d              = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Same-sign operands giving a different-sign sum is exactly
                    // carry-into-MSB XOR carry-out-of-MSB.
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = (a_slice[CHUNK-1] ~^ b_slice[CHUNK-1]) &
                              (chunk_sum[CHUNK-1] ^ a_slice[CHUNK-1]);
                    zero_d  = (s_d == '0);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign Ready = ready_q;
    assign Done  = done_q;
    assign S     = s_q;
    assign Cout  = cout_q;
    assign Ovf   = ovf_q;
    assign Zero  = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder (WIDTH=16, CHUNK=4): stimulus pushes expected
// results, a negedge monitor pops and compares on every Done pulse.
module tb_chunked_adder;

    localparam int  W   = 16;
    localparam int  C   = 4;
    localparam int  NCH = W / C;
    localparam time T   = 10;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
        time          t_done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, cin, sub;
    logic [W-1:0] a, b;
    logic         ready, done, cout, ovf, zero;
    logic [W-1:0] s;

    int   checks = 0;
    int   errors = 0;
    int   n_push = 0;
    int   n_done = 0;
    exp_t q[$];
    exp_t e_mon;

    chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .CLK(clk), .RST(rst), .Start(start), .A(a), .B(b), .Cin(cin), .SUB(sub),
        .Ready(ready), .Done(done), .S(s), .Cout(cout), .Ovf(ovf), .Zero(zero)
    );

    always #(T/2) clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e_mon = q.pop_front();
                check("S", 64'(s), 64'(e_mon.s));
                check("Cout", 64'(cout), 64'(e_mon.cout));
                check("Ovf", 64'(ovf), 64'(e_mon.ovf));
                check("Zero", 64'(zero), 64'(e_mon.zero));
                check("done_time", 64'($time), 64'(e_mon.t_done));
                check("ready_during_done", 64'(ready), 64'd0);
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] es, input logic ec, input logic eo,
                            input logic ez, input time td);
        exp_t e;
        e.s = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.t_done = td;
        q.push_back(e);
        n_push++;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 64'(ready), 64'd1);
    endtask

    // Done is sampled on the negedge that falls NCH cycles after the accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         input logic isub, input logic [W-1:0] es, input logic ec,
                         input logic eo, input logic ez);
        wait_ready();
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(posedge clk);
        push_exp(es, ec, eo, ez, $time + NCH * T + T/2);
        #1 start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        int  n;
        rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_S", 64'(s), 64'd0);
        check("rst_Cout", 64'(cout), 64'd0);
        check("rst_Ovf", 64'(ovf), 64'd0);
        check("rst_Zero", 64'(zero), 64'd0);

        issue(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        issue(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Start pulse during RUN must not be accepted nor disturb the latched operands.
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ready_in_run", 64'(ready), 64'd0);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        check("ready_in_run2", 64'(ready), 64'd0);
        start = 1'b0;

        // Reset on the 2nd RUN edge aborts with no Done.
        wait_ready();
        a = 16'h0009; b = 16'h0009; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_S", 64'(s), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_Cout", 64'(cout), 64'd0);
        issue(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back ops every NCH+2 cycles; inputs change after acceptance.
        wait_ready();
        a = 16'h00FF; b = 16'h0F01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        t0 = $time;
        push_exp(16'h1000, 1'b0, 1'b0, 1'b0, t0 + NCH * T + T/2);
        push_exp(16'h7FFF, 1'b1, 1'b1, 1'b0, t0 + (NCH + 2) * T + NCH * T + T/2);
        #1 a = 16'h8000; b = 16'h0001; cin = 1'b1; sub = 1'b1;
        repeat (NCH + 2) @(posedge clk);
        #1 start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_push));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
